// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for dm_window_streamer.
//   state_t     - streamer FSM states
//   ceil_div    - integer ceiling division used to size words-per-window
//   WPW_DEFAULT - words per window for the default 3x3 8-bit / 32-bit configuration
package dm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  localparam int unsigned WPW_DEFAULT = ceil_div(3 * 3 * 8, 32);

endpackage

// File: rtl/dm_word_packer.sv
// dm_word_packer: delays the BRAM read enable by RD_LAT cycles to form a capture
// strobe, tracks which word of the window is arriving, and scatters the elements
// of each DWIDTH-bit word into an N_ELEM*BW window register (element 0 in LSBs).
// Bytes of the final word beyond N_ELEM are dropped.
// Ports:
//   clk, rst  clock, async active-high reset
//   clr       restart word indexing (new run)
//   rd_en     read enable issued to the BRAM this cycle
//   q         BRAM read data
//   last      strobe for the final word of a window (window complete on this edge)
//   window    assembled window
module dm_word_packer
  import dm_pkg::*;
#(
  parameter int unsigned N_ELEM = 9,
  parameter int unsigned BW     = 8,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   rd_en,
  input  logic [DWIDTH-1:0]      q,
  output logic                   last,
  output logic [N_ELEM*BW-1:0]   window
);

  localparam int unsigned EPW = DWIDTH / BW;
  localparam int unsigned WPW = ceil_div(N_ELEM * BW, DWIDTH);
  localparam int unsigned IW  = (WPW > 1) ? $clog2(WPW) : 1;

  logic [RD_LAT-1:0]    pipe;
  logic                 strobe;
  logic [IW-1:0]        idx;
  logic [N_ELEM*BW-1:0] buffer;

  assign strobe = pipe[RD_LAT-1];
  assign last   = strobe && (idx == IW'(WPW - 1));
  assign window = buffer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe   <= '0;
      idx    <= '0;
      buffer <= '0;
    end else begin
      pipe[0] <= rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      if (clr) begin
        idx <= '0;
      end else if (strobe) begin
        // Each element belongs to word e/EPW at lane e%EPW.
        for (int unsigned e = 0; e < N_ELEM; e++) begin
          if (idx == IW'(e / EPW)) buffer[e*BW +: BW] <= q[(e % EPW)*BW +: BW];
        end
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_window_streamer.sv
// dm_window_streamer: streams NUM windows of KHxKW ifmap/weight elements read from
// BRAM0/BRAM1 (packed DWIDTH-bit words) to a CNN kernel over valid/ready, and writes
// every kernel result to BRAM2 at consecutive addresses.
// Build option: define DM_WEIGHT_REUSE_EN to read weights only for the first window
// and hold them for the rest of the run; otherwise weights are re-read per window.
// Ports:
//   clk, rst                 clock, async active-high reset
//   i_run, i_num_win         start pulse (IDLE only) and window count latched on start
//   o_idle, o_done           FSM idle, one-cycle run-complete pulse
//   addr_b0/en_b0/q_b0       ifmap read port
//   addr_b1/en_b1/q_b1       weight read port
//   addr_b2/en_b2/we_b2/d_b2 result write port
//   o_k_valid/i_k_ready      window handshake, o_k_fmap/o_k_weight window data
//   i_k_result/i_k_valid     kernel result (no backpressure)
module dm_window_streamer
  import dm_pkg::*;
#(
  parameter int unsigned KH     = 3,
  parameter int unsigned KW     = 3,
  parameter int unsigned IF_BW  = 8,
  parameter int unsigned W_BW   = 8,
  parameter int unsigned AC_BW  = 20,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned NW_BW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_run,
  input  logic [NW_BW-1:0]       i_num_win,
  output logic                   o_idle,
  output logic                   o_done,
  output logic [AWIDTH-1:0]      addr_b0,
  output logic                   en_b0,
  input  logic [DWIDTH-1:0]      q_b0,
  output logic [AWIDTH-1:0]      addr_b1,
  output logic                   en_b1,
  input  logic [DWIDTH-1:0]      q_b1,
  output logic [AWIDTH-1:0]      addr_b2,
  output logic                   en_b2,
  output logic                   we_b2,
  output logic [DWIDTH-1:0]      d_b2,
  output logic                   o_k_valid,
  input  logic                   i_k_ready,
  output logic [KH*KW*IF_BW-1:0] o_k_fmap,
  output logic [KH*KW*W_BW-1:0]  o_k_weight,
  input  logic [AC_BW-1:0]       i_k_result,
  input  logic                   i_k_valid
);

  localparam int unsigned N_ELEM = KH * KW;
  localparam int unsigned WPW    = ceil_div(N_ELEM * IF_BW, DWIDTH);
  localparam int unsigned IW     = $clog2(WPW + 1);

  state_t            state, state_nx;
  logic [NW_BW-1:0]  num;
  logic [NW_BW-1:0]  win_sent;
  logic [NW_BW-1:0]  res_done;
  logic [IW-1:0]     issue_cnt;
  logic [AWIDTH-1:0] rd_addr0, rd_addr1, wr_addr;
  logic              start, issue, hs, wr, load_done;
  logic              fmap_last, wt_last;
  logic              more_windows;

`ifdef DM_WEIGHT_REUSE_EN
  logic first_win;
`endif

  assign start        = (state == S_IDLE) && i_run;
  assign issue        = (state == S_LOAD) && (issue_cnt != IW'(WPW));
  assign hs           = (state == S_SEND) && i_k_ready;
  assign wr           = i_k_valid && (state != S_IDLE);
  // The weight packer only ever finishes on the same edge as the ifmap packer.
  assign load_done    = fmap_last || wt_last;
  assign more_windows = ({1'b0, win_sent} + 1'b1) < {1'b0, num};

  assign addr_b0 = rd_addr0;
  assign addr_b1 = rd_addr1;
  assign en_b0   = issue;
`ifdef DM_WEIGHT_REUSE_EN
  assign en_b1   = issue && first_win;
`else
  assign en_b1   = issue;
`endif

  assign addr_b2 = wr_addr;
  assign en_b2   = wr;
  assign we_b2   = wr;
  assign d_b2    = wr ? {{(DWIDTH-AC_BW){1'b0}}, i_k_result} : '0;

  always_comb begin
    state_nx  = state;
    o_idle    = 1'b0;
    o_done    = 1'b0;
    o_k_valid = 1'b0;
    case (state)
      S_IDLE: begin
        o_idle = 1'b1;
        if (i_run) state_nx = (i_num_win == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (load_done) state_nx = S_SEND;
      end
      S_SEND: begin
        o_k_valid = 1'b1;
        if (i_k_ready) state_nx = more_windows ? S_LOAD : S_DRAIN;
      end
      S_DRAIN: begin
        if (res_done == num) state_nx = S_DONE;
      end
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      num       <= '0;
      win_sent  <= '0;
      res_done  <= '0;
      issue_cnt <= '0;
      rd_addr0  <= '0;
      rd_addr1  <= '0;
      wr_addr   <= '0;
`ifdef DM_WEIGHT_REUSE_EN
      first_win <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (start) begin
        num       <= i_num_win;
        win_sent  <= '0;
        res_done  <= '0;
        issue_cnt <= '0;
        rd_addr0  <= '0;
        rd_addr1  <= '0;
        wr_addr   <= '0;
`ifdef DM_WEIGHT_REUSE_EN
        first_win <= 1'b1;
`endif
      end
      if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
        rd_addr0  <= rd_addr0 + 1'b1;
        if (en_b1) rd_addr1 <= rd_addr1 + 1'b1;
      end
      if (hs) begin
        win_sent  <= win_sent + 1'b1;
        issue_cnt <= '0;
`ifdef DM_WEIGHT_REUSE_EN
        first_win <= 1'b0;
`endif
      end
      if (wr) begin
        wr_addr  <= wr_addr + 1'b1;
        res_done <= res_done + 1'b1;
      end
    end
  end

  dm_word_packer #(
    .N_ELEM (N_ELEM),
    .BW     (IF_BW),
    .DWIDTH (DWIDTH),
    .RD_LAT (RD_LAT)
  ) u_fmap_packer (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .rd_en  (en_b0),
    .q      (q_b0),
    .last   (fmap_last),
    .window (o_k_fmap)
  );

  dm_word_packer #(
    .N_ELEM (N_ELEM),
    .BW     (W_BW),
    .DWIDTH (DWIDTH),
    .RD_LAT (RD_LAT)
  ) u_weight_packer (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .rd_en  (en_b1),
    .q      (q_b1),
    .last   (wt_last),
    .window (o_k_weight)
  );

endmodule

// File: tb/tb_dm_window_streamer.sv
// Self-checking bench for dm_window_streamer (default 3x3, 8-bit, 32-bit words).
// RD_LAT can be overridden to exercise longer BRAM latency; DM_WEIGHT_REUSE_EN
// switches the weight expectations to the reuse behaviour.
module tb_dm_window_streamer #(
  parameter int unsigned RD_LAT = 1
);

  logic        clk = 1'b0;
  logic        rst;
  logic        i_run;
  logic [7:0]  i_num_win;
  logic        o_idle, o_done;
  logic [7:0]  addr_b0, addr_b1, addr_b2;
  logic        en_b0, en_b1, en_b2, we_b2;
  logic [31:0] q_b0, q_b1, d_b2;
  logic        o_k_valid, i_k_ready;
  logic [71:0] o_k_fmap, o_k_weight;
  logic [19:0] i_k_result;
  logic        i_k_valid;

  always #5 clk = ~clk;

  dm_window_streamer #(
    .KH(3), .KW(3), .IF_BW(8), .W_BW(8), .AC_BW(20),
    .DWIDTH(32), .AWIDTH(8), .RD_LAT(RD_LAT), .NW_BW(8)
  ) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_num_win(i_num_win),
    .o_idle(o_idle), .o_done(o_done),
    .addr_b0(addr_b0), .en_b0(en_b0), .q_b0(q_b0),
    .addr_b1(addr_b1), .en_b1(en_b1), .q_b1(q_b1),
    .addr_b2(addr_b2), .en_b2(en_b2), .we_b2(we_b2), .d_b2(d_b2),
    .o_k_valid(o_k_valid), .i_k_ready(i_k_ready),
    .o_k_fmap(o_k_fmap), .o_k_weight(o_k_weight),
    .i_k_result(i_k_result), .i_k_valid(i_k_valid)
  );

  // ---------------- memories and BRAM read model ----------------
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] p0 [RD_LAT];
  logic [31:0] p1 [RD_LAT];

  always @(posedge clk) begin
    if (en_b0) p0[0] <= mem0[addr_b0];
    if (en_b1) p1[0] <= mem1[addr_b1];
    for (int i = 1; i < RD_LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign q_b0 = p0[RD_LAT-1];
  assign q_b1 = p1[RD_LAT-1];

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int stall_len, stall_cnt, res_delay;
  int win_idx, rd0_idx, rd1_idx, wr_idx, done_cnt, done_cyc, run_cyc;
  int due_q[$];
  logic [19:0] val_q[$];
  bit prev_valid, prev_hs;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Window n occupies words n*3.. of the packed byte stream; element e is byte e%4 of word e/4.
  function automatic logic [71:0] exp_fmap(input int n);
    logic [71:0] r;
    int w;
    for (int e = 0; e < 9; e++) begin
      w = (n * 3 + e / 4) % 256;
      r[e*8 +: 8] = mem0[w][(e % 4)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [71:0] exp_wt(input int n);
    logic [71:0] r;
    int w, base;
`ifdef DM_WEIGHT_REUSE_EN
    base = 0;
`else
    base = n * 3;
`endif
    for (int e = 0; e < 9; e++) begin
      w = (base + e / 4) % 256;
      r[e*8 +: 8] = mem1[w][(e % 4)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [19:0] res_val(input int k);
    return 20'h12345 + 20'(k) * 20'h01111;
  endfunction

  function automatic int exp_wt_reads(input int num);
`ifdef DM_WEIGHT_REUSE_EN
    return (num > 0) ? 3 : 0;
`else
    return num * 3;
`endif
  endfunction

  // ---------------- kernel-side drivers ----------------
  initial begin
    i_k_ready = 1'b0;
    stall_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || !o_k_valid) begin
        i_k_ready = 1'b0;
        stall_cnt = 0;
      end else if (stall_cnt < stall_len) begin
        i_k_ready = 1'b0;
        stall_cnt++;
      end else begin
        i_k_ready = 1'b1;
      end
    end
  end

  initial begin
    i_k_valid  = 1'b0;
    i_k_result = '0;
    forever begin
      @(posedge clk); #1;
      i_k_valid  = 1'b0;
      i_k_result = '0;
      if (!rst && due_q.size() > 0 && due_q[0] <= cyc) begin
        i_k_valid  = 1'b1;
        i_k_result = val_q[0];
        void'(due_q.pop_front());
        void'(val_q.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) check("valid_held", o_k_valid, 1'b1);
      if (o_k_valid) begin
        check("fmap_win", o_k_fmap, exp_fmap(win_idx));
        check("weight_win", o_k_weight, exp_wt(win_idx));
      end
      prev_valid = o_k_valid;
      prev_hs    = o_k_valid && i_k_ready;
      if (o_k_valid && i_k_ready) begin
        due_q.push_back(cyc + res_delay);
        val_q.push_back(res_val(win_idx));
        win_idx++;
      end
      if (en_b0) begin
        check("addr_b0", addr_b0, 8'(rd0_idx));
        rd0_idx++;
      end
      if (en_b1) begin
`ifdef DM_WEIGHT_REUSE_EN
        check("addr_b1", addr_b1, 8'(rd1_idx));
`else
        check("addr_b1", addr_b1, 8'(rd1_idx));
`endif
        rd1_idx++;
      end
      if (en_b2) begin
        check("we_b2", we_b2, 1'b1);
        check("addr_b2", addr_b2, 8'(wr_idx));
        check("d_b2", d_b2, {12'h000, res_val(wr_idx)});
        mem2[addr_b2] = d_b2;
        wr_idx++;
      end
      if (o_done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  // ---------------- directed sequences ----------------
  task automatic clear_model();
    win_idx = 0; rd0_idx = 0; rd1_idx = 0; wr_idx = 0;
    done_cnt = 0; done_cyc = 0;
    due_q.delete();
    val_q.delete();
    for (int i = 0; i < 256; i++) mem2[i] = '0;
  endtask

  task automatic start_run(input int num, input int stall, input int rdel);
    @(posedge clk); #1;
    clear_model();
    stall_len = stall;
    res_delay = rdel;
    i_num_win = 8'(num);
    i_run     = 1'b1;
    run_cyc   = cyc;
    @(posedge clk); #1;
    i_run = 1'b0;
  endtask

  task automatic finish_run(input string name, input int num);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check({name, "_done_seen"}, done_cnt != 0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_once"}, done_cnt, 1);
    check({name, "_idle"}, o_idle, 1'b1);
    check({name, "_windows"}, win_idx, num);
    check({name, "_writes"}, wr_idx, num);
    check({name, "_b0_reads"}, rd0_idx, num * 3);
    check({name, "_b1_reads"}, rd1_idx, exp_wt_reads(num));
    for (int k = 0; k < num; k++) check({name, "_bram2"}, mem2[k], {12'h000, res_val(k)});
  endtask

  initial begin
    int t;
    bit found;
    rst = 1'b1; i_run = 1'b0; i_num_win = '0;
    stall_len = 0; res_delay = 2;
    clear_model();
    for (int w = 0; w < 256; w++)
      for (int j = 0; j < 4; j++) begin
        mem0[w][j*8 +: 8] = 8'((4 * w + j + 1) % 256);
        mem1[w][j*8 +: 8] = 8'(((4 * w + j) * 7 + 8'h40) % 256);
      end
    mem0[2] = 32'hDDCCBB09;
    for (int i = 0; i < RD_LAT; i++) begin p0[i] = '0; p1[i] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", o_idle, 1'b1);
    check("rst_done", o_done, 1'b0);
    check("rst_valid", o_k_valid, 1'b0);
    check("rst_en", {en_b0, en_b1, en_b2, we_b2}, 4'b0000);
    check("rst_addr", {addr_b0, addr_b1, addr_b2}, 24'h0);
    check("rst_data", {o_k_fmap, o_k_weight, d_b2}, '0);
    rst = 1'b0;

    // A result arriving while idle must not be written
    @(posedge clk); #1;
    clear_model();
    due_q.push_back(cyc + 1);
    val_q.push_back(20'hABCDE);
    repeat (4) @(posedge clk);
    #1;
    check("idle_result_ignored", wr_idx, 0);

    // Single window: literal window contents, latency, BRAM2[0]
    start_run(1, 0, 3);
    t = 0;
    while (!o_k_valid && t < 100) begin @(negedge clk); t++; end
    check("t1_valid_seen", o_k_valid, 1'b1);
    check("t1_latency", cyc - run_cyc, 4 + RD_LAT);
    check("t1_fmap_lit", o_k_fmap, 72'h090807060504030201);
    check("t1_weight_lit", o_k_weight, 72'h78716A635C554E4740);
    finish_run("t1", 1);
    check("t1_bram2_lit", mem2[0], 32'h00012345);

    // Four windows with 5-cycle ready stalls; mid-run i_run/i_num_win changes ignored
    start_run(4, 5, 2);
    repeat (3) @(posedge clk);
    #1;
    i_run = 1'b1; i_num_win = 8'd9;
    @(posedge clk); #1;
    i_run = 1'b0;
    finish_run("t2", 4);
    check("t2_last_b0_addr", rd0_idx - 1, 11);

    // Zero windows: immediate completion, no BRAM traffic
    start_run(0, 0, 2);
    finish_run("t3", 0);
    check("t3_done_latency_ok", (done_cyc - run_cyc >= 1) && (done_cyc - run_cyc <= 2), 1'b1);

    // Result lands in the same cycle as the next window handshake
    start_run(3, 0, 5);
    finish_run("t4", 3);

    // Two windows with single-cycle stalls
    start_run(2, 1, 1);
    finish_run("t5", 2);

    // Async reset in the middle of loading window 2, then a fresh run from address 0
    start_run(4, 0, 2);
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(posedge clk); #2;
      if (win_idx == 2 && en_b0 === 1'b1) found = 1'b1;
    end
    check("t6_reached_load2", found, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_idle", o_idle, 1'b1);
    check("t6_rst_en", {en_b0, en_b1, en_b2, o_k_valid}, 4'b0000);
    check("t6_rst_fmap", o_k_fmap, 72'h0);
    due_q.delete();
    val_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start_run(2, 0, 2);
    finish_run("t6", 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
